// File: rtl/dyser_port_endpoint.sv
// Core<->DySER endpoint: eight send-side input-port FIFOs feeding the fabric and eight
// output-port FIFOs serving recv. Define DYSER_RECV_BYPASS_EN to let a recv take fabric data directly.
module dyser_port_endpoint #(
   parameter int DW    = 64,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   send_data_r0,
   input  logic [DW-1:0]   send_data_r1,
   input  logic [2:0]      send_port_r0,
   input  logic [2:0]      send_port_r1,
   input  logic            send_en0,
   input  logic            send_en1,
   output logic            send_stall,
   input  logic [2:0]      recv_port_r0,
   input  logic [2:0]      recv_port_r1,
   input  logic            recv_en0,
   input  logic            recv_en1,
   output logic [DW-1:0]   recv_data_r0,
   output logic [DW-1:0]   recv_data_r1,
   output logic            recv_stall,
   input  logic            config_en,
   output logic [8*DW-1:0] in_data,
   output logic [7:0]      in_valid,
   input  logic [7:0]      in_ready,
   input  logic [8*DW-1:0] out_data,
   input  logic [7:0]      out_valid,
   output logic [7:0]      out_ready
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int CW1 = CW + 1;
   localparam logic [CW-1:0] FULL   = CW'(DEPTH);
   localparam logic [CW:0]   FULL_W = CW1'(DEPTH);

   logic [7:0]    send_over;
   logic [7:0]    recv_under;
   logic [1:0]    take [8];
   logic [CW-1:0] of_count [8];
   logic [DW-1:0] of_head [8];
   logic [DW-1:0] of_second [8];
   logic [7:0]    bypass_ok;
   logic [7:0]    bypass_take;
   logic          any_recv;
   logic          same_port;

   assign any_recv    = recv_en0 | recv_en1;
   assign send_stall  = rst & (config_en | (|send_over));
   assign recv_stall  = !rst ? any_recv : ((config_en & any_recv) | (|recv_under));
   assign bypass_take = bypass_ok & {8{~recv_stall}};

   genvar gi;

   // Input-port FIFOs: both lanes land in one cycle, lane 0 first when they share a port.
   generate
      for (gi = 0; gi < 8; gi++) begin : g_if
         logic [DW-1:0] mem [DEPTH];
         logic [PW-1:0] wr_ptr_reg;
         logic [PW-1:0] rd_ptr_reg;
         logic [CW-1:0] count_reg;
         logic          hit0;
         logic          hit1;
         logic          pop;
         logic [1:0]    need;
         logic [1:0]    need_acc;
         logic [PW-1:0] wr_ptr_lane1;

         assign hit0          = send_en0 && (send_port_r0 == 3'(gi));
         assign hit1          = send_en1 && (send_port_r1 == 3'(gi));
         assign need          = {1'b0, hit0} + {1'b0, hit1};
         assign send_over[gi] = ({1'b0, count_reg} + CW1'(need)) > FULL_W;
         assign need_acc      = send_stall ? 2'd0 : need;
         assign wr_ptr_lane1  = wr_ptr_reg + PW'(hit0);
         assign in_valid[gi]  = (count_reg != '0) && !config_en;
         assign pop           = in_valid[gi] && in_ready[gi];
         assign in_data[gi*DW +: DW] = mem[rd_ptr_reg];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else if (config_en) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               wr_ptr_reg <= wr_ptr_reg + PW'(need_acc);
               rd_ptr_reg <= rd_ptr_reg + PW'(pop);
               count_reg  <= count_reg + CW'(need_acc) - CW'(pop);
            end
         end

         always_ff @(posedge clk) begin
            if (!send_stall && !config_en) begin
               if (hit0) mem[wr_ptr_reg]   <= send_data_r0;
               if (hit1) mem[wr_ptr_lane1] <= send_data_r1;
            end
         end
      end
   endgenerate

   // Output-port FIFOs: the fabric pushes, recv lanes pop up to two entries per cycle.
   generate
      for (gi = 0; gi < 8; gi++) begin : g_of
         logic [DW-1:0] mem [DEPTH];
         logic [PW-1:0] wr_ptr_reg;
         logic [PW-1:0] rd_ptr_reg;
         logic [PW-1:0] rd_ptr_second;
         logic [CW-1:0] count_reg;
         logic          hit0;
         logic          hit1;
         logic          push;
         logic [1:0]    pop_n;

         assign hit0           = recv_en0 && (recv_port_r0 == 3'(gi));
         assign hit1           = recv_en1 && (recv_port_r1 == 3'(gi));
         assign take[gi]       = {1'b0, hit0} + {1'b0, hit1};
         assign of_count[gi]   = count_reg;
         assign rd_ptr_second  = rd_ptr_reg + PW'(1);
         assign of_head[gi]    = mem[rd_ptr_reg];
         assign of_second[gi]  = mem[rd_ptr_second];
         assign out_ready[gi]  = !rst || ((count_reg != FULL) && !config_en);

`ifdef DYSER_RECV_BYPASS_EN
         assign bypass_ok[gi]  = (take[gi] == 2'd1) && (count_reg == '0) && out_valid[gi];
`else
         assign bypass_ok[gi]  = 1'b0;
`endif

         assign recv_under[gi] = ({1'b0, count_reg} < CW1'(take[gi])) && !bypass_ok[gi];
         assign push           = out_valid[gi] && out_ready[gi] && !bypass_take[gi];
         assign pop_n          = (recv_stall || bypass_ok[gi]) ? 2'd0 : take[gi];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else if (config_en) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               wr_ptr_reg <= wr_ptr_reg + PW'(push);
               rd_ptr_reg <= rd_ptr_reg + PW'(pop_n);
               count_reg  <= count_reg + CW'(push) - CW'(pop_n);
            end
         end

         always_ff @(posedge clk) begin
            if (push && !config_en) mem[wr_ptr_reg] <= out_data[gi*DW +: DW];
         end
      end
   endgenerate

   // Lane 1 sees the second entry when lane 0 already claims the same port's head.
   always_comb begin
      recv_data_r0 = '0;
      recv_data_r1 = '0;
      same_port    = recv_en0 && (recv_port_r0 == recv_port_r1);
      if (rst) begin
         if (of_count[recv_port_r0] != '0)
            recv_data_r0 = of_head[recv_port_r0];
         else if (bypass_ok[recv_port_r0])
            recv_data_r0 = out_data[int'(recv_port_r0)*DW +: DW];

         if (same_port) begin
            if (of_count[recv_port_r1] >= CW'(2))
               recv_data_r1 = of_second[recv_port_r1];
         end else if (of_count[recv_port_r1] != '0) begin
            recv_data_r1 = of_head[recv_port_r1];
         end else if (bypass_ok[recv_port_r1]) begin
            recv_data_r1 = out_data[int'(recv_port_r1)*DW +: DW];
         end
      end
   end

endmodule

// File: tb/tb_dyser_port_endpoint.sv
// Bench for dyser_port_endpoint: directed scenarios plus randomized traffic against a queue model.
module tb_dyser_port_endpoint;
   localparam int DW    = 64;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [DW-1:0]   send_data_r0 = '0;
   logic [DW-1:0]   send_data_r1 = '0;
   logic [2:0]      send_port_r0 = '0;
   logic [2:0]      send_port_r1 = '0;
   logic            send_en0 = 1'b0;
   logic            send_en1 = 1'b0;
   logic            send_stall;
   logic [2:0]      recv_port_r0 = '0;
   logic [2:0]      recv_port_r1 = '0;
   logic            recv_en0 = 1'b0;
   logic            recv_en1 = 1'b0;
   logic [DW-1:0]   recv_data_r0;
   logic [DW-1:0]   recv_data_r1;
   logic            recv_stall;
   logic            config_en = 1'b0;
   logic [8*DW-1:0] in_data;
   logic [7:0]      in_valid;
   logic [7:0]      in_ready = '0;
   logic [8*DW-1:0] out_data = '0;
   logic [7:0]      out_valid = '0;
   logic [7:0]      out_ready;

   int total = 0;
   int bad   = 0;

   // Reference model: each FIFO is a list with index 0 as the head.
   logic [DW-1:0] mif [8][DEPTH];
   logic [DW-1:0] mof [8][DEPTH];
   int            mif_n [8];
   int            mof_n [8];

   always #5 clk = ~clk;

   dyser_port_endpoint #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .send_data_r0(send_data_r0), .send_data_r1(send_data_r1),
      .send_port_r0(send_port_r0), .send_port_r1(send_port_r1),
      .send_en0(send_en0), .send_en1(send_en1), .send_stall(send_stall),
      .recv_port_r0(recv_port_r0), .recv_port_r1(recv_port_r1),
      .recv_en0(recv_en0), .recv_en1(recv_en1),
      .recv_data_r0(recv_data_r0), .recv_data_r1(recv_data_r1), .recv_stall(recv_stall),
      .config_en(config_en),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic idle();
      send_en0 = 1'b0; send_en1 = 1'b0; recv_en0 = 1'b0; recv_en1 = 1'b0;
      send_port_r0 = '0; send_port_r1 = '0; recv_port_r0 = '0; recv_port_r1 = '0;
      send_data_r0 = '0; send_data_r1 = '0;
      config_en = 1'b0; in_ready = '0; out_valid = '0; out_data = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int p = 0; p < 8; p++) begin
         mif_n[p] = 0;
         mof_n[p] = 0;
      end
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0;
      recv_en0 = 1'b1; config_en = 1'b1; send_en0 = 1'b1;
      @(negedge clk); #1;
      $display("reset: in_valid=%02h out_ready=%02h send_stall=%0b recv_stall=%0b", in_valid, out_ready, send_stall, recv_stall);
      total++; if (in_valid !== 8'h00) begin bad++; $display("FAIL reset_in_valid got=%02h exp=00", in_valid); end
      total++; if (out_ready !== 8'hFF) begin bad++; $display("FAIL reset_out_ready got=%02h exp=ff", out_ready); end
      total++; if (send_stall !== 1'b0) begin bad++; $display("FAIL reset_send_stall got=%0b exp=0", send_stall); end
      total++; if (recv_stall !== 1'b1) begin bad++; $display("FAIL reset_recv_stall got=%0b exp=1", recv_stall); end
      total++; if (recv_data_r0 !== '0) begin bad++; $display("FAIL reset_recv_data got=%0h exp=0", recv_data_r0); end
      recv_en0 = 1'b0; #1;
      total++; if (recv_stall !== 1'b0) begin bad++; $display("FAIL reset_recv_stall_idle got=%0b exp=0", recv_stall); end
      idle();
      @(negedge clk);
      rst = 1'b1; #1;
      total++; if (out_ready !== 8'hFF) begin bad++; $display("FAIL reset_out_ready_after got=%02h exp=ff", out_ready); end
   endtask

   task automatic test_send_basic();
      do_reset();
      send_en0 = 1'b1; send_port_r0 = 3'd4; send_data_r0 = 64'h0;
      send_en1 = 1'b1; send_port_r1 = 3'd3; send_data_r1 = 64'h1;
      #1;
      total++; if (send_stall !== 1'b0) begin bad++; $display("FAIL send_basic_stall got=%0b exp=0", send_stall); end
      @(negedge clk);
      idle(); #1;
      $display("send_basic: in_valid=%02h", in_valid);
      total++; if (in_valid !== 8'h18) begin bad++; $display("FAIL send_basic_valid got=%02h exp=18", in_valid); end
      total++; if (in_data[4*DW +: DW] !== 64'h0) begin bad++; $display("FAIL send_basic_data4 got=%0h exp=0", in_data[4*DW +: DW]); end
      total++; if (in_data[3*DW +: DW] !== 64'h1) begin bad++; $display("FAIL send_basic_data3 got=%0h exp=1", in_data[3*DW +: DW]); end
   endtask

   task automatic test_send_full();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send_en0 = 1'b1; send_port_r0 = 3'd2; send_data_r0 = 64'hA0 + 64'(i);
         @(negedge clk);
         $display("send_full: wrote %0h to port 2", 64'hA0 + 64'(i));
      end
      send_data_r0 = 64'hA4;
      send_en1 = 1'b1; send_port_r1 = 3'd5; send_data_r1 = 64'h5A;
      #1;
      total++; if (send_stall !== 1'b1) begin bad++; $display("FAIL full_stall got=%0b exp=1", send_stall); end
      @(negedge clk); #1;
      total++; if (in_valid[5] !== 1'b0) begin bad++; $display("FAIL full_partner got=%0b exp=0", in_valid[5]); end
      in_ready[2] = 1'b1; #1;
      total++; if (send_stall !== 1'b1) begin bad++; $display("FAIL full_pop_cycle_stall got=%0b exp=1", send_stall); end
      total++; if (in_data[2*DW +: DW] !== 64'hA0) begin bad++; $display("FAIL full_head got=%0h exp=a0", in_data[2*DW +: DW]); end
      @(negedge clk);
      in_ready = '0; #1;
      total++; if (send_stall !== 1'b0) begin bad++; $display("FAIL full_after_pop_stall got=%0b exp=0", send_stall); end
      @(negedge clk);
      idle(); #1;
      $display("send_full: in_valid=%02h", in_valid);
      total++; if (in_valid[5] !== 1'b1) begin bad++; $display("FAIL full_partner_written got=%0b exp=1", in_valid[5]); end
      total++; if (in_data[5*DW +: DW] !== 64'h5A) begin bad++; $display("FAIL full_partner_data got=%0h exp=5a", in_data[5*DW +: DW]); end
      total++; if (in_data[2*DW +: DW] !== 64'hA1) begin bad++; $display("FAIL full_next_head got=%0h exp=a1", in_data[2*DW +: DW]); end
   endtask

   task automatic test_recv();
      do_reset();
      out_valid[0] = 1'b1; out_data[0 +: DW] = 64'h55 | 64'hFF;
      @(negedge clk);
      out_valid = '0; recv_en0 = 1'b1; recv_port_r0 = 3'd0; #1;
      $display("recv: data=%0h stall=%0b", recv_data_r0, recv_stall);
      total++; if (recv_stall !== 1'b0) begin bad++; $display("FAIL recv_first_stall got=%0b exp=0", recv_stall); end
      total++; if (recv_data_r0 !== 64'hFF) begin bad++; $display("FAIL recv_first_data got=%0h exp=ff", recv_data_r0); end
      @(negedge clk); #1;
      total++; if (recv_stall !== 1'b1) begin bad++; $display("FAIL recv_empty_stall got=%0b exp=1", recv_stall); end
      recv_en0 = 1'b0; out_valid[0] = 1'b1; out_data[0 +: DW] = 64'h77;
      @(negedge clk);
      out_valid = '0; recv_en0 = 1'b1; #1;
      $display("recv: data=%0h stall=%0b", recv_data_r0, recv_stall);
      total++; if (recv_stall !== 1'b0) begin bad++; $display("FAIL recv_second_stall got=%0b exp=0", recv_stall); end
      total++; if (recv_data_r0 !== 64'h77) begin bad++; $display("FAIL recv_second_data got=%0h exp=77", recv_data_r0); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_dual_recv();
      do_reset();
      out_valid[5] = 1'b1; out_data[5*DW +: DW] = 64'h11;
      @(negedge clk);
      out_valid = '0;
      recv_en0 = 1'b1; recv_port_r0 = 3'd5; recv_en1 = 1'b1; recv_port_r1 = 3'd5; #1;
      total++; if (recv_stall !== 1'b1) begin bad++; $display("FAIL dual_one_entry_stall got=%0b exp=1", recv_stall); end
      @(negedge clk);
      out_valid[5] = 1'b1; out_data[5*DW +: DW] = 64'h22; #1;
      total++; if (recv_stall !== 1'b1) begin bad++; $display("FAIL dual_no_pop_stall got=%0b exp=1", recv_stall); end
      @(negedge clk);
      out_valid = '0; #1;
      $display("dual_recv: r0=%0h r1=%0h stall=%0b", recv_data_r0, recv_data_r1, recv_stall);
      total++; if (recv_stall !== 1'b0) begin bad++; $display("FAIL dual_two_stall got=%0b exp=0", recv_stall); end
      total++; if (recv_data_r0 !== 64'h11) begin bad++; $display("FAIL dual_r0 got=%0h exp=11", recv_data_r0); end
      total++; if (recv_data_r1 !== 64'h22) begin bad++; $display("FAIL dual_r1 got=%0h exp=22", recv_data_r1); end
      @(negedge clk);
      recv_en1 = 1'b0; #1;
      total++; if (recv_stall !== 1'b1) begin bad++; $display("FAIL dual_drained got=%0b exp=1", recv_stall); end
      idle();
   endtask

   task automatic test_config();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         send_en0 = 1'b1; send_port_r0 = 3'd1; send_data_r0 = 64'(i);
         send_en1 = 1'b1; send_port_r1 = 3'd7; send_data_r1 = 64'(i + 8);
         out_valid = 8'h0F; out_data = {8{64'hC0DE}};
         @(negedge clk);
      end
      config_en = 1'b1;
      for (int c = 0; c < 17; c++) begin
         #1;
         $display("config cycle %0d: in_valid=%02h out_ready=%02h", c, in_valid, out_ready);
         total++; if (in_valid !== 8'h00) begin bad++; $display("FAIL config_in_valid got=%02h exp=00", in_valid); end
         total++; if (out_ready !== 8'h00) begin bad++; $display("FAIL config_out_ready got=%02h exp=00", out_ready); end
         total++; if (send_stall !== 1'b1) begin bad++; $display("FAIL config_send_stall got=%0b exp=1", send_stall); end
         @(negedge clk);
      end
      idle(); #1;
      total++; if (in_valid !== 8'h00) begin bad++; $display("FAIL config_after_valid got=%02h exp=00", in_valid); end
      total++; if (out_ready !== 8'hFF) begin bad++; $display("FAIL config_after_ready got=%02h exp=ff", out_ready); end
      recv_en0 = 1'b1; recv_port_r0 = 3'd0; #1;
      total++; if (recv_stall !== 1'b1) begin bad++; $display("FAIL config_of_empty got=%0b exp=1", recv_stall); end
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_en0 = 1'b1; send_port_r0 = 3'd6; send_data_r0 = 64'h61;
      send_en1 = 1'b1; send_port_r1 = 3'd6; send_data_r1 = 64'h62;
      @(negedge clk);
      send_en1 = 1'b0; #1;
      total++; if (in_valid[6] !== 1'b1) begin bad++; $display("FAIL mid_before got=%0b exp=1", in_valid[6]); end
      #2 rst = 1'b0;
      #1;
      $display("reset_mid: in_valid=%02h", in_valid);
      total++; if (in_valid[6] !== 1'b0) begin bad++; $display("FAIL mid_drop got=%0b exp=0", in_valid[6]); end
      idle();
      @(negedge clk);
      rst = 1'b1; #1;
      total++; if (in_valid !== 8'h00) begin bad++; $display("FAIL mid_after got=%02h exp=00", in_valid); end
   endtask

`ifdef DYSER_RECV_BYPASS_EN
   task automatic test_bypass();
      do_reset();
      out_valid[1] = 1'b1; out_data[1*DW +: DW] = 64'h4;
      recv_en0 = 1'b1; recv_port_r0 = 3'd1; #1;
      $display("bypass: data=%0h stall=%0b", recv_data_r0, recv_stall);
      total++; if (recv_stall !== 1'b0) begin bad++; $display("FAIL bypass_stall got=%0b exp=0", recv_stall); end
      total++; if (recv_data_r0 !== 64'h4) begin bad++; $display("FAIL bypass_data got=%0h exp=4", recv_data_r0); end
      total++; if (out_ready[1] !== 1'b1) begin bad++; $display("FAIL bypass_ready got=%0b exp=1", out_ready[1]); end
      @(negedge clk);
      out_valid = '0; #1;
      total++; if (recv_stall !== 1'b1) begin bad++; $display("FAIL bypass_not_enqueued got=%0b exp=1", recv_stall); end
      idle();
   endtask
`endif

   task automatic test_random(input int cycles);
      logic [7:0]      e_in_valid;
      logic [7:0]      e_out_ready;
      logic [7:0]      byp;
      logic            e_send_stall;
      logic            e_recv_stall;
      logic [8*DW-1:0] e_in_data;
      logic [8*DW-1:0] mask;
      logic [DW-1:0]   e_r0;
      logic [DW-1:0]   e_r1;
      int              nd [8];
      int              tk [8];
      do_reset();
      for (int c = 0; c < cycles; c++) begin
         send_en0 = 1'($urandom_range(0, 1)); send_port_r0 = 3'($urandom_range(0, 3));
         send_en1 = 1'($urandom_range(0, 1)); send_port_r1 = 3'($urandom_range(0, 3));
         send_data_r0 = {$urandom, $urandom}; send_data_r1 = {$urandom, $urandom};
         recv_en0 = 1'($urandom_range(0, 1)); recv_port_r0 = 3'($urandom_range(0, 3));
         recv_en1 = 1'($urandom_range(0, 1)); recv_port_r1 = 3'($urandom_range(0, 3));
         in_ready = 8'($urandom & $urandom);
         out_valid = 8'($urandom);
         for (int p = 0; p < 8; p++) out_data[p*DW +: DW] = {$urandom, $urandom};
         config_en = ($urandom_range(0, 39) == 0);

         e_send_stall = config_en;
         e_recv_stall = config_en && (recv_en0 || recv_en1);
         e_in_data = '0; mask = '0;
         for (int p = 0; p < 8; p++) begin
            nd[p] = int'(send_en0 && send_port_r0 == 3'(p)) + int'(send_en1 && send_port_r1 == 3'(p));
            tk[p] = int'(recv_en0 && recv_port_r0 == 3'(p)) + int'(recv_en1 && recv_port_r1 == 3'(p));
            e_in_valid[p]  = (mif_n[p] != 0) && !config_en;
            e_out_ready[p] = (mof_n[p] != DEPTH) && !config_en;
`ifdef DYSER_RECV_BYPASS_EN
            byp[p] = (tk[p] == 1) && (mof_n[p] == 0) && out_valid[p];
`else
            byp[p] = 1'b0;
`endif
            if (mif_n[p] + nd[p] > DEPTH) e_send_stall = 1'b1;
            if (mof_n[p] < tk[p] && !byp[p]) e_recv_stall = 1'b1;
            if (mif_n[p] != 0) begin
               e_in_data[p*DW +: DW] = mif[p][0];
               mask[p*DW +: DW] = '1;
            end
         end
         e_r0 = (mof_n[recv_port_r0] > 0) ? mof[recv_port_r0][0]
              : (byp[recv_port_r0] ? out_data[int'(recv_port_r0)*DW +: DW] : '0);
         if (recv_en0 && recv_port_r0 == recv_port_r1)
            e_r1 = (mof_n[recv_port_r1] > 1) ? mof[recv_port_r1][1] : '0;
         else
            e_r1 = (mof_n[recv_port_r1] > 0) ? mof[recv_port_r1][0]
                 : (byp[recv_port_r1] ? out_data[int'(recv_port_r1)*DW +: DW] : '0);
         #1;
         $display("rand %0d: send_stall=%0b recv_stall=%0b in_valid=%02h out_ready=%02h cfg=%0b", c, send_stall, recv_stall, in_valid, out_ready, config_en);
         total++; if (send_stall !== e_send_stall) begin bad++; $display("FAIL rand_send_stall cyc=%0d got=%0b exp=%0b", c, send_stall, e_send_stall); end
         total++; if (recv_stall !== e_recv_stall) begin bad++; $display("FAIL rand_recv_stall cyc=%0d got=%0b exp=%0b", c, recv_stall, e_recv_stall); end
         total++; if (in_valid !== e_in_valid) begin bad++; $display("FAIL rand_in_valid cyc=%0d got=%02h exp=%02h", c, in_valid, e_in_valid); end
         total++; if (out_ready !== e_out_ready) begin bad++; $display("FAIL rand_out_ready cyc=%0d got=%02h exp=%02h", c, out_ready, e_out_ready); end
         total++; if ((in_data & mask) !== e_in_data) begin bad++; $display("FAIL rand_in_data cyc=%0d valid=%02h", c, e_in_valid); end
         if (recv_en0 && !e_recv_stall) begin
            total++; if (recv_data_r0 !== e_r0) begin bad++; $display("FAIL rand_recv_r0 cyc=%0d got=%0h exp=%0h", c, recv_data_r0, e_r0); end
         end
         if (recv_en1 && !e_recv_stall) begin
            total++; if (recv_data_r1 !== e_r1) begin bad++; $display("FAIL rand_recv_r1 cyc=%0d got=%0h exp=%0h", c, recv_data_r1, e_r1); end
         end
         @(posedge clk);
         if (config_en) begin
            for (int p = 0; p < 8; p++) begin mif_n[p] = 0; mof_n[p] = 0; end
         end else begin
            for (int p = 0; p < 8; p++) begin
               if (e_in_valid[p] && in_ready[p]) begin
                  for (int i = 0; i < DEPTH - 1; i++) mif[p][i] = mif[p][i+1];
                  mif_n[p]--;
               end
            end
            if (!e_send_stall) begin
               if (send_en0) begin mif[send_port_r0][mif_n[send_port_r0]] = send_data_r0; mif_n[send_port_r0]++; end
               if (send_en1) begin mif[send_port_r1][mif_n[send_port_r1]] = send_data_r1; mif_n[send_port_r1]++; end
            end
            for (int p = 0; p < 8; p++) begin
               if (!e_recv_stall && !byp[p]) begin
                  for (int k = 0; k < tk[p]; k++) begin
                     for (int i = 0; i < DEPTH - 1; i++) mof[p][i] = mof[p][i+1];
                     mof_n[p]--;
                  end
               end
               if (out_valid[p] && e_out_ready[p] && !(byp[p] && !e_recv_stall)) begin
                  mof[p][mof_n[p]] = out_data[p*DW +: DW];
                  mof_n[p]++;
               end
            end
         end
         @(negedge clk);
      end
      idle();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_send_basic();
      test_send_full();
      test_recv();
      test_dual_recv();
      test_config();
      test_reset_mid();
`ifdef DYSER_RECV_BYPASS_EN
      test_bypass();
`endif
      test_random(400);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
